// File: rtl/ram_port_arbiter.sv
// Two-master (instruction fetch / data) front end for the SRAM driver.
// Serialises word transactions and turns partial-word stores into read-modify-write.
module ram_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_enable,
  output logic        mem_re,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RMW_RD_WAIT,
    RMW_WR_WAIT
  } state_t;

  state_t state;
  logic   gnt_d;

  // Byte addresses above the 8 MiB window and the in-word offset do not reach the driver.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:23], i_addr[1:0], d_addr[31:23], d_addr[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] new_w,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int n = 0; n < int'(LANES); n++) begin
      if (be[n]) w[n*LANE_W +: LANE_W] = new_w[n*LANE_W +: LANE_W];
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      i_rdata    <= '0;
      i_ready    <= 1'b0;
      d_rdata    <= '0;
      d_ready    <= 1'b0;
      mem_enable <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Strobes and completion pulses default low so each lasts exactly one cycle.
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      unique case (state)
        IDLE: begin
          if (d_req) begin
            gnt_d <= 1'b1;
            if (!d_we) begin
              mem_addr   <= d_addr[22:2];
              mem_re     <= 1'b1;
              mem_enable <= 1'b1;
              state      <= RD_WAIT;
            end else if (d_be == 4'b1111) begin
              mem_addr   <= d_addr[22:2];
              mem_wdata  <= d_wdata;
              mem_we     <= 1'b1;
              mem_enable <= 1'b1;
              state      <= WR_WAIT;
            end else if (d_be == 4'b0000) begin
              d_ready <= 1'b1;
            end else begin
              mem_addr   <= d_addr[22:2];
              mem_re     <= 1'b1;
              mem_enable <= 1'b1;
              state      <= RMW_RD_WAIT;
            end
          end else if (i_req) begin
            gnt_d      <= 1'b0;
            mem_addr   <= i_addr[22:2];
            mem_re     <= 1'b1;
            mem_enable <= 1'b1;
            state      <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_ack) begin
            if (gnt_d) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end
            mem_enable <= 1'b0;
            state      <= IDLE;
          end
        end

        WR_WAIT: begin
          if (mem_ack) begin
            d_ready    <= 1'b1;
            mem_enable <= 1'b0;
            state      <= IDLE;
          end
        end

        // Old word is back: splice in the enabled lanes and write it to the same address.
        RMW_RD_WAIT: begin
          if (mem_ack) begin
            mem_wdata <= merge_lanes(d_wdata, mem_rdata, d_be);
            mem_we    <= 1'b1;
            state     <= RMW_WR_WAIT;
          end
        end

        RMW_WR_WAIT: begin
          if (mem_ack) begin
            d_ready    <= 1'b1;
            mem_enable <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          mem_enable <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
